uart_axis: RTL and testbench

UART_AXIS -- requirements
Module: uart_axis

---
 rtl/uart_axis.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_axis.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_axis.sv
// UART transceiver (8N1) with AXI-Stream byte interfaces on both directions.
// Bit time is prescale*8 clocks, latched at the start of every frame.
module uart_axis #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    output logic                  txd,
    input  logic [15:0]           prescale,
    output logic                  tx_busy,
    output logic                  rx_busy,
    output logic                  rx_overrun_error,
    output logic                  rx_frame_error
);

    localparam int CNT_W = 19;
    localparam int IDX_W = $clog2(DATA_WIDTH + 2);

    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    function automatic logic [15:0] eff_ps(input logic [15:0] ps);
        return (ps == 16'd0) ? 16'd1 : ps;
    endfunction

    // ---------------- transmitter ----------------
    tx_state_e             tx_state_q, tx_state_d;
    logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
    logic [CNT_W-1:0]      tx_len_q, tx_len_d;
    logic [IDX_W-1:0]      tx_idx_q, tx_idx_d;
    logic [DATA_WIDTH:0]   tx_shreg_q, tx_shreg_d;
    logic                  txd_q, txd_d;
    logic                  tx_rdy_q, tx_rdy_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_len_d   = tx_len_q;
        tx_idx_d   = tx_idx_q;
        tx_shreg_d = tx_shreg_q;
        txd_d      = txd_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (s_axis_tvalid && tx_rdy_q) begin
                    tx_len_d   = {eff_ps(prescale), 3'b000} - CNT_W'(1);
                    tx_cnt_d   = tx_len_d;
                    tx_shreg_d = {1'b1, s_axis_tdata};
                    tx_idx_d   = '0;
                    txd_d      = 1'b0;
                    tx_state_d = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = tx_len_q;
                    if (tx_idx_q == IDX_W'(DATA_WIDTH + 1)) begin
                        txd_d      = 1'b1;
                        tx_state_d = TX_IDLE;
                    end else begin
                        // Shift register holds the remaining data bits followed by the stop bit.
                        txd_d      = tx_shreg_q[0];
                        tx_shreg_d = tx_shreg_q >> 1;
                        tx_idx_d   = tx_idx_q + IDX_W'(1);
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_W'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        tx_rdy_d = (tx_state_d == TX_IDLE);
    end

    // NOTE: clocked blocks use <= only, so every register sees pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_len_q   <= '0;
            tx_idx_q   <= '0;
            txd_q      <= 1'b1;
            tx_rdy_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_len_q   <= tx_len_d;
            tx_idx_q   <= tx_idx_d;
            txd_q      <= txd_d;
            tx_rdy_q   <= tx_rdy_d;
        end
    end

    // ---------------- receiver ----------------
    rx_state_e             rx_state_q, rx_state_d;
    logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
    logic [CNT_W-1:0]      rx_len_q, rx_len_d;
    logic [IDX_W-1:0]      rx_idx_q, rx_idx_d;
    logic [DATA_WIDTH-1:0] rx_shreg_q, rx_shreg_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_ovr_q, rx_ovr_d;
    logic                  rx_ferr_q, rx_ferr_d;
    logic                  rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic [15:0]           rx_ps;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_len_d   = rx_len_q;
        rx_idx_d   = rx_idx_q;
        rx_shreg_d = rx_shreg_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q && !m_axis_tready;
        rx_ovr_d   = 1'b0;
        rx_ferr_d  = 1'b0;
        rx_ps      = eff_ps(prescale);
        case (rx_state_q)
            RX_IDLE: begin
                if (rxd_prev_q && !rxd_sync_q) begin
                    rx_len_d   = {rx_ps, 3'b000} - CNT_W'(1);
                    rx_cnt_d   = {1'b0, rx_ps, 2'b00} - CNT_W'(1);
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == '0) begin
                    // A start bit that is high again at its midpoint was only a glitch.
                    if (rxd_sync_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_cnt_d   = rx_len_q;
                        rx_idx_d   = '0;
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_cnt_d   = rx_len_q;
                    rx_shreg_d = {rxd_sync_q, rx_shreg_q[DATA_WIDTH-1:1]};
                    if (rx_idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + IDX_W'(1);
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d = RX_IDLE;
                    if (rxd_sync_q) begin
                        rx_data_d  = rx_shreg_q;
                        rx_valid_d = 1'b1;
                        rx_ovr_d   = rx_valid_q && !m_axis_tready;
                    end else begin
                        rx_ferr_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_len_q   <= '0;
            rx_idx_q   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_len_q   <= rx_len_d;
            rx_idx_q   <= rx_idx_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    // NOTE: shift registers are not reset; each frame fully reloads them before they are read.
    always_ff @(posedge clk) begin
        tx_shreg_q <= tx_shreg_d;
        rx_shreg_q <= rx_shreg_d;
    end

    assign s_axis_tready    = tx_rdy_q;
    assign txd              = txd_q;
    assign tx_busy          = (tx_state_q == TX_SHIFT);
    assign m_axis_tdata     = rx_data_q;
    assign m_axis_tvalid    = rx_valid_q;
    assign rx_busy          = (rx_state_q != RX_IDLE);
    assign rx_overrun_error = rx_ovr_q;
    assign rx_frame_error   = rx_ferr_q;

endmodule

// File: tb/tb_uart_axis.sv
// Self-checking bench for uart_axis: frame-level TX/RX reference model with
// randomized bytes and prescales, plus directed glitch, overrun and reset cases.
module tb_uart_axis;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [W-1:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         rxd_drv;
    logic         loopback;
    logic         rxd_w;
    logic         txd;
    logic [15:0]  prescale;
    logic         tx_busy, rx_busy, rx_overrun_error, rx_frame_error;

    int n_vec = 0;
    int n_err = 0;
    int ferr_hi = 0;
    int ovr_hi = 0;
    int exp_ferr = 0;
    int exp_ovr = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    assign rxd_w = loopback ? txd : rxd_drv;

    uart_axis #(.DATA_WIDTH(W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .rxd              (rxd_w),
        .txd              (txd),
        .prescale         (prescale),
        .tx_busy          (tx_busy),
        .rx_busy          (rx_busy),
        .rx_overrun_error (rx_overrun_error),
        .rx_frame_error   (rx_frame_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int bit_clks(input logic [15:0] p);
        return 8 * ((p == 16'd0) ? 1 : int'(p));
    endfunction

    // Error flags are counted per high cycle, so a one-clock pulse adds exactly one.
    always @(negedge clk) begin
        if (rx_frame_error)   ferr_hi++;
        if (rx_overrun_error) ovr_hi++;
    end

    // Scoreboard: each accepted received byte must match the oldest expected byte.
    always @(negedge clk) begin
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            check("rx_byte_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("rx_data", m_axis_tdata, exp_q.pop_front());
        end
    end

    task automatic wait_tx_ready();
        int guard = 0;
        while (!s_axis_tready && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("tx_ready_wait", s_axis_tready, 1'b1);
    endtask

    // Sends one byte and checks the full txd waveform clock by clock.
    task automatic tx_frame(input logic [W-1:0] data, input logic [15:0] p, input bit scramble);
        int   bt = bit_clks(p);
        logic [W+1:0] frame = {1'b1, data, 1'b0};
        wait_tx_ready();
        s_axis_tdata  = data;
        s_axis_tvalid = 1'b1;
        prescale      = p;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        if (scramble) prescale = 16'($urandom);
        for (int i = 0; i < (W + 2) * bt; i++) begin
            check("txd_bit", txd, frame[i / bt]);
            check("tx_tready_low", s_axis_tready, 1'b0);
            check("tx_busy_high", tx_busy, 1'b1);
            @(negedge clk);
        end
        check("txd_idle_after", txd, 1'b1);
        check("tx_tready_back", s_axis_tready, 1'b1);
        check("tx_busy_after", tx_busy, 1'b0);
    endtask

    // Drives one serial frame on rxd and records what the receiver should produce.
    task automatic rx_send(input logic [W-1:0] data, input logic [15:0] p, input logic stop);
        int   bt = bit_clks(p);
        logic [W+1:0] frame = {stop, data, 1'b0};
        if (stop) exp_q.push_back(data);
        else      exp_ferr++;
        prescale = p;
        for (int i = 0; i < (W + 2) * bt; i++) begin
            rxd_drv = frame[i / bt];
            @(negedge clk);
        end
        rxd_drv = 1'b1;
    endtask

    task automatic rx_settle(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_ferr"}, ferr_hi, exp_ferr);
        check({tag, "_ovr"}, ovr_hi, exp_ovr);
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_rx_busy"}, rx_busy, 1'b0);
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] d;
        logic [15:0]  p;
        int           lat;

        rst_n         = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        rxd_drv       = 1'b1;
        loopback      = 1'b0;
        prescale      = 16'd1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1'b1);
        check("rst_tready", s_axis_tready, 1'b0);
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tx_busy", tx_busy, 1'b0);
        check("rst_rx_busy", rx_busy, 1'b0);
        check("rst_ovr", rx_overrun_error, 1'b0);
        check("rst_ferr", rx_frame_error, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_tready", s_axis_tready, 1'b1);

        // TX: 0xA5 at prescale 1, then prescale 0 (treated as 1), then back-to-back random frames
        tx_frame(8'hA5, 16'd1, 1'b1);
        tx_frame(W'($urandom), 16'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tx_frame(W'($urandom), 16'($urandom_range(0, 3)), 1'b1);
        end

        // RX: random frames, some with a bad stop bit
        for (int k = 0; k < 8; k++) begin
            d = W'($urandom);
            p = 16'($urandom_range(0, 3));
            rx_send(d, p, ($urandom_range(0, 3) != 0));
            repeat ($urandom_range(1, 4)) @(negedge clk);
            rx_settle("rx_rand");
        end

        // Frame error: 0x3C with stop bit 0
        rx_send(8'h3C, 16'd1, 1'b0);
        rx_settle("rx_ferr");

        // Overrun: nothing consumed, 0x11 then 0x22
        m_axis_tready = 1'b0;
        rx_send(8'h11, 16'd1, 1'b1);
        repeat (2) @(negedge clk);
        check("ovr_first_valid", m_axis_tvalid, 1'b1);
        check("ovr_first_data", m_axis_tdata, 8'h11);
        rx_send(8'h22, 16'd1, 1'b1);
        repeat (2) @(negedge clk);
        void'(exp_q.pop_front());   // the unread 0x11 is overwritten
        exp_ovr++;
        check("ovr_count", ovr_hi, exp_ovr);
        check("ovr_valid_held", m_axis_tvalid, 1'b1);
        check("ovr_data", m_axis_tdata, 8'h22);
        m_axis_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ovr_valid_cleared", m_axis_tvalid, 1'b0);
        rx_settle("rx_ovr");

        // Glitch: 3-clock low pulse at prescale 4
        prescale = 16'd4;
        rxd_drv  = 1'b0;
        repeat (3) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_rx_busy_set", rx_busy, 1'b1);
        repeat (40) @(negedge clk);
        rx_settle("glitch");

        // Concurrent TX and RX
        fork
            tx_frame(W'($urandom), 16'd2, 1'b0);
            rx_send(W'($urandom), 16'd2, 1'b1);
        join
        rx_settle("concurrent");

        // Loopback at prescale 13: stop bit is judged at its centre, ~9.5 bit times in
        loopback = 1'b1;
        exp_q.push_back(8'h77);
        wait_tx_ready();
        s_axis_tdata  = 8'h77;
        s_axis_tvalid = 1'b1;
        prescale      = 16'd13;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        lat = 1;
        while (!m_axis_tvalid && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        check("loop_valid_seen", m_axis_tvalid, 1'b1);
        check("loop_latency_window", 32'(lat >= 76 * 13 && lat <= 80 * 13 + 8), 32'd1);
        wait_tx_ready();
        loopback = 1'b0;
        rx_settle("loopback");

        // Reset in the middle of a TX frame and an RX frame
        wait_tx_ready();
        s_axis_tdata  = W'($urandom);
        s_axis_tvalid = 1'b1;
        prescale      = 16'd2;
        rxd_drv       = 1'b0;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_txd", txd, 1'b1);
        check("mid_rst_tready", s_axis_tready, 1'b0);
        check("mid_rst_tx_busy", tx_busy, 1'b0);
        check("mid_rst_rx_busy", rx_busy, 1'b0);
        check("mid_rst_tdata", m_axis_tdata, 0);
        rxd_drv = 1'b1;
        rst_n   = 1'b1;
        @(negedge clk);
        check("mid_rel_tready", s_axis_tready, 1'b1);
        repeat (200) @(negedge clk);
        check("mid_rst_txd_idle", txd, 1'b1);
        check("mid_rst_no_valid", m_axis_tvalid, 1'b0);
        rx_settle("mid_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
